// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN control path: output-size helper,
// sequencer state encoding and counter sizing.
package cnn_pkg;

  // Layer sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  // Spatial output size of a valid, stride-1 convolution.
  function automatic int OUTPUT_SIZE(input int in_size, input int k_size);
    return in_size - k_size + 1;
  endfunction

  // Bits needed to hold a counter value in 0..max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control/strobe bundle between the NN controller, the layer sequencer
// and the conv datapath memories.
interface conv_layer_sequencer_if #(
  parameter int ADDR_BITS = 16
);

  logic                 start;
  logic                 stall;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] in_addr;
  logic [ADDR_BITS-1:0] w_addr;
  logic [ADDR_BITS-1:0] b_addr;
  logic                 mac_valid;
  logic                 mac_first;
  logic                 mac_last;
  logic [ADDR_BITS-1:0] out_addr;

  // Sequencer side: takes start/stall, drives addresses and strobes.
  modport master (
    input  start, stall,
    output busy, done, in_addr, w_addr, b_addr,
           mac_valid, mac_first, mac_last, out_addr
  );

  // Controller/datapath side.
  modport slave (
    output start, stall,
    input  busy, done, in_addr, w_addr, b_addr,
           mac_valid, mac_first, mac_last, out_addr
  );

endinterface

// File: rtl/nest_counter.sv
// Wrap counter for one level of a loop nest. Counts 0..MAX while enabled,
// wraps to 0, and raises carry on the enabled cycle that wraps so the next
// outer level can be chained on it.
module nest_counter #(
  parameter int MAX   = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign carry = en && (count == MAX_V);

  // Next count: clear beats enable; a carry wraps back to zero.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (carry) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = count + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Time-multiplexed single-MAC schedule for one conv layer. Walks
// r, c, f, ky, kx, d (outermost first), presents input/weight/bias read
// addresses, and one cycle later (matching the memory read latency) emits
// the MAC strobes and the output write address for the term just read.
module conv_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int INPUT_HEIGHT   = 4,
  parameter int INPUT_WIDTH    = 4,
  parameter int INPUT_DEPTH    = 1,
  parameter int KERNEL_HEIGHT  = 3,
  parameter int KERNEL_WIDTH   = 3,
  parameter int FILTERS_NUMBER = 2,
  parameter int ADDR_BITS      = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  conv_layer_sequencer_if.master bus
);

  localparam int OH = OUTPUT_SIZE(INPUT_HEIGHT, KERNEL_HEIGHT);
  localparam int OW = OUTPUT_SIZE(INPUT_WIDTH, KERNEL_WIDTH);

  // Largest address each output can take.
  localparam longint IN_MAX  = longint'(INPUT_HEIGHT) * INPUT_WIDTH * INPUT_DEPTH - 1;
  localparam longint W_MAX   = longint'(FILTERS_NUMBER) * KERNEL_HEIGHT * KERNEL_WIDTH
                               * INPUT_DEPTH - 1;
  localparam longint OUT_MAX = longint'(OH) * OW * FILTERS_NUMBER - 1;
  localparam longint B_MAX   = longint'(FILTERS_NUMBER) - 1;
  localparam longint A_LIMIT = (longint'(1) << ADDR_BITS) - 1;

  if (ADDR_BITS < 1 || ADDR_BITS > 32) begin : g_bad_addr_bits
    $error("conv_layer_sequencer: ADDR_BITS must be in 1..32");
  end
  if (OH < 1 || OW < 1 || INPUT_DEPTH < 1 || FILTERS_NUMBER < 1) begin : g_bad_shape
    $error("conv_layer_sequencer: kernel larger than input or empty dimension");
  end
  if (IN_MAX > A_LIMIT || W_MAX > A_LIMIT || OUT_MAX > A_LIMIT || B_MAX > A_LIMIT)
  begin : g_addr_overflow
    $error("conv_layer_sequencer: an address maximum does not fit in ADDR_BITS");
  end

  localparam int RW = cnt_bits(OH - 1);
  localparam int CW = cnt_bits(OW - 1);
  localparam int FW = cnt_bits(FILTERS_NUMBER - 1);
  localparam int YW = cnt_bits(KERNEL_HEIGHT - 1);
  localparam int XW = cnt_bits(KERNEL_WIDTH - 1);
  localparam int DW = cnt_bits(INPUT_DEPTH - 1);

  seq_state_e state_q, next_state;

  logic start_layer;
  logic fire;
  logic load_addr;

  logic [RW-1:0] r_q, r_nxt;
  logic [CW-1:0] c_q, c_nxt;
  logic [FW-1:0] f_q, f_nxt;
  logic [YW-1:0] y_q, y_nxt;
  logic [XW-1:0] x_q, x_nxt;
  logic [DW-1:0] d_q, d_nxt;
  logic          r_co, c_co, f_co, y_co, x_co, d_co;

  logic [ADDR_BITS-1:0] in_addr_d, w_addr_d, b_addr_d, out_addr_d;
  logic [ADDR_BITS-1:0] in_addr_q, w_addr_q, b_addr_q, out_addr_q;
  logic                 busy_q, done_q;
  logic                 mac_valid_q, mac_first_q, mac_last_q;

  assign start_layer = (state_q == IDLE) && bus.start;
  assign fire        = (state_q == RUN) && !bus.stall;

  // The final fire leaves the addresses on the last term so that an idle
  // sequencer still shows where it finished.
  assign load_addr   = start_layer || (fire && !r_co);

  // Loop nest, innermost (d) first; each level steps on the carry of the one inside.
  nest_counter #(.MAX(INPUT_DEPTH - 1), .WIDTH(DW)) u_cnt_d (
    .clk(clk), .rst_n(rst_n), .clr(start_layer), .en(fire),
    .count(d_q), .count_nxt(d_nxt), .carry(d_co)
  );
  nest_counter #(.MAX(KERNEL_WIDTH - 1), .WIDTH(XW)) u_cnt_x (
    .clk(clk), .rst_n(rst_n), .clr(start_layer), .en(d_co),
    .count(x_q), .count_nxt(x_nxt), .carry(x_co)
  );
  nest_counter #(.MAX(KERNEL_HEIGHT - 1), .WIDTH(YW)) u_cnt_y (
    .clk(clk), .rst_n(rst_n), .clr(start_layer), .en(x_co),
    .count(y_q), .count_nxt(y_nxt), .carry(y_co)
  );
  nest_counter #(.MAX(FILTERS_NUMBER - 1), .WIDTH(FW)) u_cnt_f (
    .clk(clk), .rst_n(rst_n), .clr(start_layer), .en(y_co),
    .count(f_q), .count_nxt(f_nxt), .carry(f_co)
  );
  nest_counter #(.MAX(OW - 1), .WIDTH(CW)) u_cnt_c (
    .clk(clk), .rst_n(rst_n), .clr(start_layer), .en(f_co),
    .count(c_q), .count_nxt(c_nxt), .carry(c_co)
  );
  nest_counter #(.MAX(OH - 1), .WIDTH(RW)) u_cnt_r (
    .clk(clk), .rst_n(rst_n), .clr(start_layer), .en(c_co),
    .count(r_q), .count_nxt(r_nxt), .carry(r_co)
  );

  // Read addresses for the index the counters move to; output address for
  // the index being fired now. Truncation to ADDR_BITS is intentional.
  assign in_addr_d = ADDR_BITS'(((32'(r_nxt) + 32'(y_nxt)) * 32'(INPUT_WIDTH)
                                 + 32'(c_nxt) + 32'(x_nxt)) * 32'(INPUT_DEPTH)
                                + 32'(d_nxt));
  assign w_addr_d  = ADDR_BITS'(((32'(f_nxt) * 32'(KERNEL_HEIGHT) + 32'(y_nxt))
                                 * 32'(KERNEL_WIDTH) + 32'(x_nxt)) * 32'(INPUT_DEPTH)
                                + 32'(d_nxt));
  assign b_addr_d  = ADDR_BITS'(32'(f_nxt));
  assign out_addr_d = ADDR_BITS'((32'(r_q) * 32'(OW) + 32'(c_q)) * 32'(FILTERS_NUMBER)
                                 + 32'(f_q));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic; start outside IDLE and stall outside RUN are ignored.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (fire && r_co) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered status: busy through RUN and DRAIN, done for the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (next_state == RUN) || (next_state == DRAIN);
      done_q <= (next_state == DONE);
    end
  end

  // Read-address registers; they hold across stalls so the memory re-reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_addr_q <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
    end else if (load_addr) begin
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      b_addr_q  <= b_addr_d;
    end
  end

  // One-stage strobe pipeline aligned to the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      mac_valid_q <= fire;
      mac_first_q <= fire && (d_q == '0) && (x_q == '0) && (y_q == '0);
      mac_last_q  <= y_co;
      if (fire) begin
        out_addr_q <= out_addr_d;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_first = mac_first_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.out_addr  = out_addr_q;

endmodule
